ysyx_25040129_mem_arbiter: RTL and testbench

YSYX_25040129_MEM_ARBITER -- requirements
Module: ysyx_25040129_mem_arbiter

---
 rtl/ysyx_25040129_mem_arbiter_if.sv | 64 ++++++
 rtl/ysyx_25040129_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_ysyx_25040129_mem_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25040129_mem_arbiter_if.sv
// Bus bundle for the IFU/LSU-to-memory arbiter.
// The master modport is the arbiter's view. The slave modport is the view of
// the environment, which holds the two requesters, the memory and the flush source.
interface ysyx_25040129_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  logic                  pipeline_flush;

  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [ADDR_WIDTH-1:0] ifu_addr;
  logic                  ifu_wen;
  logic [DATA_WIDTH-1:0] ifu_wdata;
  logic [MASK_WIDTH-1:0] ifu_wmask;
  logic                  ifu_resp_valid;
  logic                  ifu_resp_ready;
  logic [DATA_WIDTH-1:0] ifu_rdata;
  logic                  ifu_err;

  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic [ADDR_WIDTH-1:0] lsu_addr;
  logic                  lsu_wen;
  logic [DATA_WIDTH-1:0] lsu_wdata;
  logic [MASK_WIDTH-1:0] lsu_wmask;
  logic                  lsu_resp_valid;
  logic                  lsu_resp_ready;
  logic [DATA_WIDTH-1:0] lsu_rdata;
  logic                  lsu_err;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [MASK_WIDTH-1:0] mem_wmask;
  logic                  mem_resp_valid;
  logic                  mem_resp_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_err;

  modport master (
    input  pipeline_flush,
    input  ifu_req_valid, ifu_addr, ifu_wen, ifu_wdata, ifu_wmask, ifu_resp_ready,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_err,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_rdata, mem_err
  );

  modport slave (
    output pipeline_flush,
    output ifu_req_valid, ifu_addr, ifu_wen, ifu_wdata, ifu_wmask, ifu_resp_ready,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_err,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_ready,
    output mem_req_ready, mem_resp_valid, mem_rdata, mem_err
  );
endinterface

// File: rtl/ysyx_25040129_mem_arbiter.sv
// Two-requester (IFU, LSU) single-outstanding memory arbiter.
// LSU has fixed priority. A pipeline flush drops an in-flight IFU response
// while still draining it from memory.
module ysyx_25040129_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ysyx_25040129_mem_arbiter_if.master bus
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  state_t                state;
  owner_t                owner;
  logic                  drop;
  logic                  req_valid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wen_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [MASK_WIDTH-1:0] wmask_q;

  logic grant_lsu;
  logic grant_ifu;
  logic flush_hit;
  logic resp_ready;
  logic resp_hs;
  logic ifu_fwd;
  logic lsu_fwd;

  // Grant decode, owner-routed response path and flush qualification
  always_comb begin
    grant_lsu  = 1'b0;
    grant_ifu  = 1'b0;
    flush_hit  = 1'b0;
    resp_ready = 1'b0;
    ifu_fwd    = 1'b0;
    lsu_fwd    = 1'b0;

    if (rst_n && state == IDLE) begin
      grant_lsu = bus.lsu_req_valid;
      grant_ifu = !bus.lsu_req_valid && bus.ifu_req_valid && !bus.pipeline_flush;
    end

    flush_hit = bus.pipeline_flush && (owner == OWN_IFU);

    // A dropped IFU response is sunk here so memory can still complete it
    if (state == WAIT) begin
      if (owner == OWN_LSU) begin
        resp_ready = bus.lsu_resp_ready;
        lsu_fwd    = bus.mem_resp_valid;
      end else if (drop) begin
        resp_ready = 1'b1;
      end else begin
        resp_ready = bus.ifu_resp_ready;
        ifu_fwd    = bus.mem_resp_valid;
      end
    end

    resp_hs = bus.mem_resp_valid && resp_ready;
  end

  // Requester-facing outputs; data and error read as zero unless the response is valid
  always_comb begin
    bus.ifu_req_ready  = grant_ifu;
    bus.lsu_req_ready  = grant_lsu;

    bus.ifu_resp_valid = ifu_fwd;
    bus.ifu_rdata      = ifu_fwd ? bus.mem_rdata : '0;
    bus.ifu_err        = ifu_fwd ? bus.mem_err : 1'b0;

    bus.lsu_resp_valid = lsu_fwd;
    bus.lsu_rdata      = lsu_fwd ? bus.mem_rdata : '0;
    bus.lsu_err        = lsu_fwd ? bus.mem_err : 1'b0;
  end

  // Memory-facing outputs driven from the captured request while it is being issued
  always_comb begin
    bus.mem_req_valid  = req_valid_q;
    bus.mem_addr       = req_valid_q ? addr_q  : '0;
    bus.mem_wen        = req_valid_q ? wen_q   : 1'b0;
    bus.mem_wdata      = req_valid_q ? wdata_q : '0;
    bus.mem_wmask      = req_valid_q ? wmask_q : '0;
    bus.mem_resp_ready = resp_ready;
  end

  // Arbitration FSM: capture on grant, hold until accepted, wait for one response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= OWN_IFU;
      drop        <= 1'b0;
      req_valid_q <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_lsu) begin
            owner       <= OWN_LSU;
            addr_q      <= bus.lsu_addr;
            wen_q       <= bus.lsu_wen;
            wdata_q     <= bus.lsu_wdata;
            wmask_q     <= bus.lsu_wmask;
            req_valid_q <= 1'b1;
            state       <= ISSUE;
          end else if (grant_ifu) begin
            owner       <= OWN_IFU;
            addr_q      <= bus.ifu_addr;
            wen_q       <= bus.ifu_wen;
            wdata_q     <= bus.ifu_wdata;
            wmask_q     <= bus.ifu_wmask;
            req_valid_q <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (flush_hit) begin
            drop <= 1'b1;
          end
          if (bus.mem_req_ready) begin
            req_valid_q <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          // A flush coinciding with the handshake is moot: the response was already delivered
          if (resp_hs) begin
            drop  <= 1'b0;
            state <= IDLE;
          end else if (flush_hit) begin
            drop <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          req_valid_q <= 1'b0;
          drop        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040129_mem_arbiter.sv
// Directed scoreboard bench for the IFU/LSU memory arbiter.
module tb_ysyx_25040129_mem_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mreq_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  mreq_t exp_mem[$];
  resp_t exp_ifu[$];
  resp_t exp_lsu[$];

  ysyx_25040129_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ysyx_25040129_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake seen on the DUT outputs consumes one expected entry
  always @(negedge clk) begin
    mreq_t am, em;
    resp_t ar, er;
    if (bus.mem_req_valid && bus.mem_req_ready) begin
      am = '{bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask};
      checks++;
      if (exp_mem.size() == 0) begin
        errors++;
        $display("FAIL mem_req unexpected: got %h (t=%0t)", am, $time);
      end else begin
        em = exp_mem.pop_front();
        if (am !== em) begin
          errors++;
          $display("FAIL mem_req: got %h expected %h (t=%0t)", am, em, $time);
        end
      end
    end
    if (bus.ifu_resp_valid && bus.ifu_resp_ready) begin
      ar = '{bus.ifu_rdata, bus.ifu_err};
      checks++;
      if (exp_ifu.size() == 0) begin
        errors++;
        $display("FAIL ifu_resp unexpected: got %h (t=%0t)", ar, $time);
      end else begin
        er = exp_ifu.pop_front();
        if (ar !== er) begin
          errors++;
          $display("FAIL ifu_resp: got %h expected %h (t=%0t)", ar, er, $time);
        end
      end
    end
    if (bus.lsu_resp_valid && bus.lsu_resp_ready) begin
      ar = '{bus.lsu_rdata, bus.lsu_err};
      checks++;
      if (exp_lsu.size() == 0) begin
        errors++;
        $display("FAIL lsu_resp unexpected: got %h (t=%0t)", ar, $time);
      end else begin
        er = exp_lsu.pop_front();
        if (ar !== er) begin
          errors++;
          $display("FAIL lsu_resp: got %h expected %h (t=%0t)", ar, er, $time);
        end
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic ifu_req(input logic v, input logic [31:0] a);
    bus.ifu_req_valid = v;
    bus.ifu_addr      = a;
    bus.ifu_wen       = 1'b0;
    bus.ifu_wdata     = '0;
    bus.ifu_wmask     = '0;
  endtask

  task automatic lsu_req(input logic v, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] m);
    bus.lsu_req_valid = v;
    bus.lsu_addr      = a;
    bus.lsu_wen       = w;
    bus.lsu_wdata     = d;
    bus.lsu_wmask     = m;
  endtask

  task automatic mem_resp(input logic v, input logic [31:0] d, input logic e);
    bus.mem_resp_valid = v;
    bus.mem_rdata      = d;
    bus.mem_err        = e;
  endtask

  task automatic all_zero(input string tag);
    chk1({tag, " ifu_req_ready"}, bus.ifu_req_ready, 1'b0);
    chk1({tag, " lsu_req_ready"}, bus.lsu_req_ready, 1'b0);
    chk1({tag, " mem_req_valid"}, bus.mem_req_valid, 1'b0);
    chk1({tag, " mem_resp_ready"}, bus.mem_resp_ready, 1'b0);
    chk1({tag, " ifu_resp_valid"}, bus.ifu_resp_valid, 1'b0);
    chk1({tag, " lsu_resp_valid"}, bus.lsu_resp_valid, 1'b0);
    chk32({tag, " mem_addr"}, bus.mem_addr, 32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.pipeline_flush = 1'b0;
    ifu_req(1'b0, 32'h0);
    lsu_req(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    bus.ifu_resp_ready = 1'b0;
    bus.lsu_resp_ready = 1'b0;
    bus.mem_req_ready  = 1'b0;
    mem_resp(1'b0, 32'h0, 1'b0);

    // Reset with requests offered: nothing may be granted
    next();
    lsu_req(1'b1, 32'h44, 1'b0, 32'h0, 4'h0);
    next();
    smp();
    all_zero("reset");

    // c0: IFU read 0x80000000
    next();
    rst_n = 1'b1;
    lsu_req(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    ifu_req(1'b1, 32'h8000_0000);
    bus.mem_req_ready = 1'b1;
    exp_mem.push_back('{32'h8000_0000, 1'b0, 32'h0, 4'h0});
    exp_ifu.push_back('{32'hDEAD_BEEF, 1'b0});
    smp();
    chk1("c0 ifu_req_ready", bus.ifu_req_ready, 1'b1);
    chk1("c0 mem_req_valid", bus.mem_req_valid, 1'b0);
    // c1: issue
    next();
    ifu_req(1'b0, 32'h0);
    smp();
    chk1("c1 mem_req_valid", bus.mem_req_valid, 1'b1);
    chk32("c1 mem_addr", bus.mem_addr, 32'h8000_0000);
    chk32("c1 ifu_rdata idle", bus.ifu_rdata, 32'h0);
    // c2: response
    next();
    mem_resp(1'b1, 32'hDEAD_BEEF, 1'b0);
    bus.ifu_resp_ready = 1'b1;
    smp();
    chk1("c2 ifu_resp_valid", bus.ifu_resp_valid, 1'b1);
    chk1("c2 lsu_resp_valid", bus.lsu_resp_valid, 1'b0);
    // c3: back in IDLE; both requesters valid, LSU wins
    next();
    mem_resp(1'b0, 32'h0, 1'b0);
    ifu_req(1'b1, 32'h100);
    lsu_req(1'b1, 32'h10, 1'b1, 32'h1234_5678, 4'hF);
    bus.lsu_resp_ready = 1'b1;
    exp_mem.push_back('{32'h10, 1'b1, 32'h1234_5678, 4'hF});
    exp_lsu.push_back('{32'h0, 1'b0});
    smp();
    chk1("c3 lsu_req_ready", bus.lsu_req_ready, 1'b1);
    chk1("c3 ifu_req_ready", bus.ifu_req_ready, 1'b0);
    chk1("c3 mem_resp_ready", bus.mem_resp_ready, 1'b0);
    // c4: LSU issue
    next();
    lsu_req(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    smp();
    chk1("c4 mem_wen", bus.mem_wen, 1'b1);
    chk1("c4 ifu_req_ready", bus.ifu_req_ready, 1'b0);
    // c5: LSU response
    next();
    mem_resp(1'b1, 32'h0, 1'b0);
    smp();
    chk1("c5 ifu_req_ready", bus.ifu_req_ready, 1'b0);
    // c6: IFU granted in the following IDLE
    next();
    mem_resp(1'b0, 32'h0, 1'b0);
    exp_mem.push_back('{32'h100, 1'b0, 32'h0, 4'h0});
    smp();
    chk1("c6 ifu_req_ready", bus.ifu_req_ready, 1'b1);
    // c7..c10: memory stalls, LSU request pending
    next();
    ifu_req(1'b0, 32'h0);
    bus.mem_req_ready = 1'b0;
    bus.ifu_resp_ready = 1'b0;
    lsu_req(1'b1, 32'h200, 1'b0, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      smp();
      chk1("stall mem_req_valid", bus.mem_req_valid, 1'b1);
      chk32("stall mem_addr", bus.mem_addr, 32'h100);
      chk1("stall lsu_req_ready", bus.lsu_req_ready, 1'b0);
      if (i < 3) next();
    end
    // c11: accepted
    next();
    lsu_req(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    bus.mem_req_ready = 1'b1;
    // c12: WAIT, flush pulse
    next();
    bus.pipeline_flush = 1'b1;
    smp();
    chk1("c12 mem_resp_ready", bus.mem_resp_ready, 1'b0);
    // c13, c14
    next();
    bus.pipeline_flush = 1'b0;
    next();
    // c15: dropped response drains
    next();
    mem_resp(1'b1, 32'hAAAA_5555, 1'b0);
    smp();
    chk1("c15 mem_resp_ready", bus.mem_resp_ready, 1'b1);
    chk1("c15 ifu_resp_valid", bus.ifu_resp_valid, 1'b0);
    chk32("c15 ifu_rdata", bus.ifu_rdata, 32'h0);
    // c16: IDLE under flush: IFU blocked, LSU granted
    next();
    mem_resp(1'b0, 32'hAAAA_5555, 1'b0);
    bus.pipeline_flush = 1'b1;
    ifu_req(1'b1, 32'h300);
    lsu_req(1'b1, 32'h20, 1'b0, 32'h0, 4'h0);
    exp_mem.push_back('{32'h20, 1'b0, 32'h0, 4'h0});
    exp_lsu.push_back('{32'hCAFE_F00D, 1'b1});
    smp();
    chk1("c16 lsu_req_ready", bus.lsu_req_ready, 1'b1);
    chk1("c16 ifu_req_ready", bus.ifu_req_ready, 1'b0);
    chk32("c16 ifu_rdata", bus.ifu_rdata, 32'h0);
    // c17: LSU issue with flush still high
    next();
    ifu_req(1'b0, 32'h0);
    lsu_req(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    // c18, c19: response held by LSU backpressure
    next();
    mem_resp(1'b1, 32'hCAFE_F00D, 1'b1);
    bus.lsu_resp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      smp();
      chk1("lsu bp mem_resp_ready", bus.mem_resp_ready, 1'b0);
      chk1("lsu bp lsu_resp_valid", bus.lsu_resp_valid, 1'b1);
      chk1("lsu bp lsu_err", bus.lsu_err, 1'b1);
      chk32("lsu bp lsu_rdata", bus.lsu_rdata, 32'hCAFE_F00D);
      next();
    end
    // c20: consumed
    bus.lsu_resp_ready = 1'b1;
    smp();
    chk1("c20 mem_resp_ready", bus.mem_resp_ready, 1'b1);
    // c21: IFU 0x40
    next();
    mem_resp(1'b0, 32'h0, 1'b0);
    bus.pipeline_flush = 1'b0;
    ifu_req(1'b1, 32'h40);
    exp_mem.push_back('{32'h40, 1'b0, 32'h0, 4'h0});
    exp_ifu.push_back('{32'h1111_2222, 1'b0});
    exp_ifu.push_back('{32'h3333_4444, 1'b0});
    smp();
    chk1("c21 ifu_req_ready", bus.ifu_req_ready, 1'b1);
    // c22: issue
    next();
    ifu_req(1'b0, 32'h0);
    // c23: flush together with the response handshake -> delivered
    next();
    bus.pipeline_flush = 1'b1;
    bus.ifu_resp_ready = 1'b1;
    mem_resp(1'b1, 32'h1111_2222, 1'b0);
    smp();
    chk1("c23 ifu_resp_valid", bus.ifu_resp_valid, 1'b1);
    // c24: IDLE with drop clear; IFU 0x44
    next();
    bus.pipeline_flush = 1'b0;
    mem_resp(1'b0, 32'h0, 1'b0);
    ifu_req(1'b1, 32'h44);
    exp_mem.push_back('{32'h44, 1'b0, 32'h0, 4'h0});
    smp();
    chk1("c24 ifu_req_ready", bus.ifu_req_ready, 1'b1);
    next();
    ifu_req(1'b0, 32'h0);
    // c26: delivered normally
    next();
    mem_resp(1'b1, 32'h3333_4444, 1'b0);
    smp();
    chk1("c26 ifu_resp_valid", bus.ifu_resp_valid, 1'b1);
    // c27: IFU 0x48, flushed during ISSUE
    next();
    mem_resp(1'b0, 32'h0, 1'b0);
    ifu_req(1'b1, 32'h48);
    exp_mem.push_back('{32'h48, 1'b0, 32'h0, 4'h0});
    next();
    ifu_req(1'b0, 32'h0);
    bus.pipeline_flush = 1'b1;
    // c29: dropped response
    next();
    bus.pipeline_flush = 1'b0;
    bus.ifu_resp_ready = 1'b0;
    mem_resp(1'b1, 32'h5555_6666, 1'b0);
    smp();
    chk1("c29 mem_resp_ready", bus.mem_resp_ready, 1'b1);
    chk1("c29 ifu_resp_valid", bus.ifu_resp_valid, 1'b0);
    // c30: LSU write 0x60, memory stalled
    next();
    mem_resp(1'b0, 32'h0, 1'b0);
    bus.mem_req_ready = 1'b0;
    lsu_req(1'b1, 32'h60, 1'b1, 32'h0F0F_0F0F, 4'h1);
    smp();
    chk1("c30 lsu_req_ready", bus.lsu_req_ready, 1'b1);
    // c31: reset during ISSUE
    next();
    rst_n = 1'b0;
    smp();
    chk1("c31 mem_req_valid", bus.mem_req_valid, 1'b1);
    chk32("c31 mem_addr", bus.mem_addr, 32'h60);
    // c32: abandoned, everything zero
    next();
    smp();
    all_zero("c32");
    // c33: first cycle after release grants a new LSU request
    next();
    rst_n = 1'b1;
    bus.mem_req_ready = 1'b1;
    lsu_req(1'b1, 32'h80, 1'b1, 32'hA5A5_A5A5, 4'h3);
    exp_mem.push_back('{32'h80, 1'b1, 32'hA5A5_A5A5, 4'h3});
    exp_lsu.push_back('{32'h0, 1'b0});
    smp();
    chk1("c33 lsu_req_ready", bus.lsu_req_ready, 1'b1);
    next();
    lsu_req(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    next();
    mem_resp(1'b1, 32'h0, 1'b0);
    next();
    mem_resp(1'b0, 32'h0, 1'b0);
    smp();
    chk1("end idle mem_req_valid", bus.mem_req_valid, 1'b0);

    chk32("leftover mem", 32'(exp_mem.size()), 32'h0);
    chk32("leftover ifu", 32'(exp_ifu.size()), 32'h0);
    chk32("leftover lsu", 32'(exp_lsu.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
